// File: rtl/sargantana_hpdc_pkg.sv
// sargantana_hpdc_pkg
// Shared memory-interface types for the HPDcache memory side, plus the
// helpers used by the request arbiter: source-index width, in-flight counter
// width/type and the remapped downstream TID layout.
package sargantana_hpdc_pkg;

  localparam int unsigned HPDCACHE_NREQUESTERS    = 2;
  localparam int unsigned HPDCACHE_MEM_TID_WIDTH  = 8;
  localparam int unsigned HPDCACHE_MEM_ADDR_WIDTH = 32;
  localparam int unsigned HPDCACHE_MEM_DATA_WIDTH = 64;
  localparam int unsigned HPDCACHE_MAX_OUTSTANDING = 4;

  typedef logic [HPDCACHE_MEM_TID_WIDTH-1:0] hpdcache_mem_id_t;

  typedef struct packed {
    logic [HPDCACHE_MEM_ADDR_WIDTH-1:0] mem_req_addr;
    logic [7:0]                         mem_req_len;
    logic [2:0]                         mem_req_size;
    hpdcache_mem_id_t                   mem_req_id;
    logic                               mem_req_cacheable;
  } hpdcache_mem_req_t;

  typedef struct packed {
    logic [1:0]                         mem_resp_r_error;
    hpdcache_mem_id_t                   mem_resp_r_id;
    logic [HPDCACHE_MEM_DATA_WIDTH-1:0] mem_resp_r_data;
    logic                               mem_resp_r_last;
  } hpdcache_mem_resp_r_t;

  // Source index field width; a single requester still reserves one bit.
  function automatic int unsigned hpdc_src_width(int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // In-flight counter width: must hold 0..max_out inclusive.
  function automatic int unsigned hpdc_cnt_width(int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

  localparam int unsigned HPDC_SRC_W = hpdc_src_width(HPDCACHE_NREQUESTERS);
  localparam int unsigned HPDC_CNT_W = hpdc_cnt_width(HPDCACHE_MAX_OUTSTANDING);

  typedef logic [HPDC_CNT_W-1:0] hpdc_outstanding_t;

  // Downstream TID: source index in the MSBs, requester TID below it.
  typedef struct packed {
    logic [HPDC_SRC_W-1:0]                        src;
    logic [HPDCACHE_MEM_TID_WIDTH-HPDC_SRC_W-1:0] tid;
  } hpdc_mem_tid_t;

endpackage

// File: rtl/sargantana_rr_arbiter.sv
// sargantana_rr_arbiter
// Round-robin selector: one-hot grant to the first requester at or after the
// priority pointer (wrapping). The pointer moves to winner+1 when en_i is set.
// Ports: clk_i, rst_i (sync, active-high), req_i[N], en_i, gnt_o[N] one-hot.
module sargantana_rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    logic found;
    int unsigned win;
    found = 1'b0;
    win   = 0;
    gnt_o = '0;
    // First pass: requesters at or above the pointer; second pass wraps.
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i >= 32'(ptr_q))) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
        win      = i;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
        win      = i;
      end
    end
    ptr_d = (win + 1 >= N) ? '0 : PTR_W'(win + 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (en_i && (|gnt_o)) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sargantana_hpdc_mem_arbiter.sv
// sargantana_hpdc_mem_arbiter
// Merges NREQ read-request channels onto one memory port and routes the
// response beats back by the source index carried in the downstream TID.
// Ports:
//   clk_i, rst_i                       clock, sync active-high reset
//   req_valid_i/req_ready_o/req_i      per-channel request handshake + payload
//   mem_req_valid_o/mem_req_ready_i    downstream request handshake
//   mem_req_o                          registered request, TID remapped
//   mem_resp_valid_i/mem_resp_ready_o  downstream response handshake
//   mem_resp_i                         response beat
//   resp_valid_o/resp_ready_i/resp_o   per-channel routed response
//   outstanding_o                      per-channel in-flight read count
//   tid_err_o                          one-cycle pulse on an illegal TID
module sargantana_hpdc_mem_arbiter
  import sargantana_hpdc_pkg::*;
#(
  parameter int unsigned NREQ            = HPDCACHE_NREQUESTERS,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TID_WIDTH       = HPDCACHE_MEM_TID_WIDTH,
  localparam int unsigned SRC_W          = hpdc_src_width(NREQ),
  localparam int unsigned CNT_W          = hpdc_cnt_width(MAX_OUTSTANDING)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic              [NREQ-1:0]        req_valid_i,
  output logic              [NREQ-1:0]        req_ready_o,
  input  hpdcache_mem_req_t [NREQ-1:0]        req_i,
  output logic                                mem_req_valid_o,
  input  logic                                mem_req_ready_i,
  output hpdcache_mem_req_t                   mem_req_o,
  input  logic                                mem_resp_valid_i,
  output logic                                mem_resp_ready_o,
  input  hpdcache_mem_resp_r_t                mem_resp_i,
  output logic              [NREQ-1:0]        resp_valid_o,
  input  logic              [NREQ-1:0]        resp_ready_i,
  output hpdcache_mem_resp_r_t [NREQ-1:0]     resp_o,
  output logic              [NREQ-1:0][CNT_W-1:0] outstanding_o,
  output logic                                tid_err_o
);

  localparam int unsigned LOW_W = TID_WIDTH - SRC_W;

  logic                       load_ok;
  logic [NREQ-1:0]            elig;
  logic [NREQ-1:0]            gnt;
  logic [NREQ-1:0]            dec;
  logic                       grant_fire;
  hpdcache_mem_req_t          sel_req;
  hpdcache_mem_req_t          fwd_req;
  hpdcache_mem_req_t          out_q;
  logic                       out_valid_q;
  logic [SRC_W-1:0]           sel_idx;
  logic [SRC_W-1:0]           resp_src;
  logic                       src_ok;
  logic                       resp_fire;
  logic                       last_fire;
  logic                       req_tid_bad;
  logic                       resp_drop;
  logic                       spurious;
  logic                       tid_err_q;
  logic [NREQ-1:0][CNT_W-1:0] cnt_q;

  // Output register can take a new request when empty or draining this cycle.
  assign load_ok = !out_valid_q || mem_req_ready_i;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = req_valid_i[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING)) && load_ok && !rst_i;
    end
  end

  sargantana_rr_arbiter #(
    .N     (NREQ),
    .PTR_W (SRC_W)
  ) u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (elig),
    .en_i  (grant_fire),
    .gnt_o (gnt)
  );

  assign grant_fire  = |gnt;
  assign req_ready_o = gnt;

  always_comb begin
    sel_req = req_i[0];
    sel_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_req = req_i[i];
        sel_idx = SRC_W'(i);
      end
    end
    fwd_req            = sel_req;
    fwd_req.mem_req_id = HPDCACHE_MEM_TID_WIDTH'({sel_idx, sel_req.mem_req_id[LOW_W-1:0]});
  end

  // Upper TID bits belong to the arbiter; a requester using them is flagged
  // but the request still goes out with the bits overwritten.
  assign req_tid_bad = grant_fire && (sel_req.mem_req_id[TID_WIDTH-1 -: SRC_W] != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (load_ok) begin
      out_valid_q <= grant_fire;
      if (grant_fire) begin
        out_q <= fwd_req;
      end
    end
  end

  assign mem_req_valid_o = out_valid_q;
  assign mem_req_o       = out_q;

  assign resp_src = mem_resp_i.mem_resp_r_id[TID_WIDTH-1 -: SRC_W];
  assign src_ok   = ({1'b0, resp_src} < (SRC_W + 1)'(NREQ));

  // Unroutable beats are swallowed so the memory side never stalls on them.
  always_comb begin
    mem_resp_ready_o = !rst_i && !src_ok;
    resp_valid_o     = '0;
    resp_o           = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      resp_o[i]               = mem_resp_i;
      resp_o[i].mem_resp_r_id = HPDCACHE_MEM_TID_WIDTH'(mem_resp_i.mem_resp_r_id[LOW_W-1:0]);
      if (src_ok && (resp_src == SRC_W'(i))) begin
        resp_valid_o[i]  = mem_resp_valid_i && !rst_i;
        mem_resp_ready_o = resp_ready_i[i] && !rst_i;
      end
    end
  end

  assign resp_fire = mem_resp_valid_i && mem_resp_ready_o;
  assign last_fire = resp_fire && src_ok && mem_resp_i.mem_resp_r_last;
  assign resp_drop = resp_fire && !src_ok;

  always_comb begin
    dec      = '0;
    spurious = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      dec[i] = last_fire && (resp_src == SRC_W'(i));
      if (dec[i] && !gnt[i] && (cnt_q[i] == '0)) begin
        spurious = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rst_i) begin
        cnt_q[i] <= '0;
      end else if (gnt[i] && !dec[i]) begin
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end else if (dec[i] && !gnt[i] && (cnt_q[i] != '0)) begin
        cnt_q[i] <= cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tid_err_q <= 1'b0;
    end else begin
      tid_err_q <= req_tid_bad || resp_drop || spurious;
    end
  end

  assign outstanding_o = cnt_q;
  assign tid_err_o     = tid_err_q;

endmodule

// File: tb/tb_sargantana_hpdc_mem_arbiter.sv
module tb_sargantana_hpdc_mem_arbiter;
  import sargantana_hpdc_pkg::*;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // NREQ=2 instance
  logic [1:0]                     a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
  hpdcache_mem_req_t [1:0]        a_req;
  logic                           a_mem_req_valid, a_mem_req_ready;
  hpdcache_mem_req_t              a_mem_req;
  logic                           a_mem_resp_valid, a_mem_resp_ready;
  hpdcache_mem_resp_r_t           a_mem_resp;
  hpdcache_mem_resp_r_t [1:0]     a_resp;
  logic [1:0][2:0]                a_outstanding;
  logic                           a_tid_err;

  // NREQ=3 instance
  logic [2:0]                     b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  hpdcache_mem_req_t [2:0]        b_req;
  logic                           b_mem_req_valid, b_mem_req_ready;
  hpdcache_mem_req_t              b_mem_req;
  logic                           b_mem_resp_valid, b_mem_resp_ready;
  hpdcache_mem_resp_r_t           b_mem_resp;
  hpdcache_mem_resp_r_t [2:0]     b_resp;
  logic [2:0][2:0]                b_outstanding;
  logic                           b_tid_err;

  sargantana_hpdc_mem_arbiter #(.NREQ(2), .MAX_OUTSTANDING(4), .TID_WIDTH(8)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_i(a_req),
    .mem_req_valid_o(a_mem_req_valid), .mem_req_ready_i(a_mem_req_ready), .mem_req_o(a_mem_req),
    .mem_resp_valid_i(a_mem_resp_valid), .mem_resp_ready_o(a_mem_resp_ready), .mem_resp_i(a_mem_resp),
    .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready), .resp_o(a_resp),
    .outstanding_o(a_outstanding), .tid_err_o(a_tid_err)
  );

  sargantana_hpdc_mem_arbiter #(.NREQ(3), .MAX_OUTSTANDING(4), .TID_WIDTH(8)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_i(b_req),
    .mem_req_valid_o(b_mem_req_valid), .mem_req_ready_i(b_mem_req_ready), .mem_req_o(b_mem_req),
    .mem_resp_valid_i(b_mem_resp_valid), .mem_resp_ready_o(b_mem_resp_ready), .mem_resp_i(b_mem_resp),
    .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready), .resp_o(b_resp),
    .outstanding_o(b_outstanding), .tid_err_o(b_tid_err)
  );

  function automatic hpdcache_mem_req_t mk_req(logic [31:0] addr, logic [7:0] id);
    hpdcache_mem_req_t r;
    r.mem_req_addr      = addr;
    r.mem_req_len       = 8'h01;
    r.mem_req_size      = 3'd3;
    r.mem_req_id        = id;
    r.mem_req_cacheable = 1'b1;
    return r;
  endfunction

  function automatic hpdcache_mem_resp_r_t mk_resp(logic [7:0] id, logic [63:0] data, logic last);
    hpdcache_mem_resp_r_t r;
    r.mem_resp_r_error = 2'b00;
    r.mem_resp_r_id    = id;
    r.mem_resp_r_data  = data;
    r.mem_resp_r_last  = last;
    return r;
  endfunction

  task automatic clear_inputs();
    a_req_valid = '0; a_req = '0; a_mem_req_ready = 1'b0;
    a_mem_resp_valid = 1'b0; a_mem_resp = '0; a_resp_ready = '0;
    b_req_valid = '0; b_req = '0; b_mem_req_ready = 1'b0;
    b_mem_resp_valid = 1'b0; b_mem_resp = '0; b_resp_ready = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req_valid = 2'b11;
    a_req[0] = mk_req(32'h10, 8'h01);
    a_req[1] = mk_req(32'h20, 8'h02);
    a_mem_resp_valid = 1'b1;
    a_mem_resp = mk_resp(8'h00, 64'h1, 1'b1);
    a_resp_ready = 2'b11;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (a_req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b want 00", a_req_ready); end
    checks++; if (a_mem_resp_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_resp_ready: got %b want 0", a_mem_resp_ready); end
    checks++; if (a_mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_req_valid: got %b want 0", a_mem_req_valid); end
    checks++; if (a_outstanding !== '0) begin errors++; $display("FAIL rst_outstanding: got %h want 0", a_outstanding); end
    checks++; if (a_tid_err !== 1'b0) begin errors++; $display("FAIL rst_tid_err: got %b want 0", a_tid_err); end
    checks++; if (b_mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_b_mem_req_valid: got %b want 0", b_mem_req_valid); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic [7:0] exp_id;
    logic [31:0] exp_addr;
    a_mem_req_ready = 1'b1;
    a_req[0] = mk_req(32'h100, 8'h0A);
    a_req[1] = mk_req(32'h200, 8'h0A);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_req_valid = (k < 4) ? 2'b11 : 2'b00;
      #1;
      if (k < 4) begin
        exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (a_req_ready !== exp_gnt) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, a_req_ready, exp_gnt); end
      end
      if (k > 0) begin
        exp_id   = ((k - 1) % 2 == 0) ? 8'h0A : 8'h8A;
        exp_addr = ((k - 1) % 2 == 0) ? 32'h100 : 32'h200;
        checks++; if (a_mem_req_valid !== 1'b1) begin errors++; $display("FAIL rr_valid%0d: got %b want 1", k, a_mem_req_valid); end
        checks++; if (a_mem_req.mem_req_id !== exp_id) begin errors++; $display("FAIL rr_tid%0d: got %h want %h", k, a_mem_req.mem_req_id, exp_id); end
        checks++; if (a_mem_req.mem_req_addr !== exp_addr) begin errors++; $display("FAIL rr_addr%0d: got %h want %h", k, a_mem_req.mem_req_addr, exp_addr); end
      end
    end
    checks++; if (a_outstanding[0] !== 3'd2 || a_outstanding[1] !== 3'd2) begin errors++; $display("FAIL rr_outstanding: got %0d/%0d want 2/2", a_outstanding[0], a_outstanding[1]); end
  endtask

  task automatic test_outstanding_limit();
    a_mem_req_ready = 1'b1;
    a_req[0] = mk_req(32'h300, 8'h01);
    a_req[1] = mk_req(32'h340, 8'h02);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_req_valid = 2'b01;
      #1;
      checks++; if (a_req_ready !== 2'b01) begin errors++; $display("FAIL lim_grant%0d: got %b want 01", k, a_req_ready); end
    end
    @(negedge clk); #1;
    checks++; if (a_req_ready !== 2'b00) begin errors++; $display("FAIL lim_stall: got %b want 00", a_req_ready); end
    checks++; if (a_outstanding[0] !== 3'd4) begin errors++; $display("FAIL lim_count: got %0d want 4", a_outstanding[0]); end
    a_req_valid = 2'b11;
    #1;
    checks++; if (a_req_ready !== 2'b10) begin errors++; $display("FAIL lim_ch1_served: got %b want 10", a_req_ready); end
    @(negedge clk);
    a_req_valid = 2'b00;
    #1;
    checks++; if (a_outstanding[1] !== 3'd1 || a_outstanding[0] !== 3'd4) begin errors++; $display("FAIL lim_counts: got %0d/%0d want 4/1", a_outstanding[0], a_outstanding[1]); end
  endtask

  task automatic test_backpressure();
    a_mem_req_ready = 1'b0;
    @(negedge clk);
    a_req[0] = mk_req(32'hA0, 8'h11);
    a_req_valid = 2'b01;
    #1;
    checks++; if (a_req_ready !== 2'b01) begin errors++; $display("FAIL bp_first_grant: got %b want 01", a_req_ready); end
    @(negedge clk);
    a_req[0] = mk_req(32'hA1, 8'h12);
    a_req[1] = mk_req(32'hB0, 8'h22);
    a_req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (a_mem_req_valid !== 1'b1 || a_mem_req.mem_req_addr !== 32'hA0 || a_mem_req.mem_req_id !== 8'h11) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b addr=%h id=%h want v=1 addr=a0 id=11", k, a_mem_req_valid, a_mem_req.mem_req_addr, a_mem_req.mem_req_id); end
      checks++; if (a_req_ready !== 2'b00) begin errors++; $display("FAIL bp_nogrant%0d: got %b want 00", k, a_req_ready); end
    end
    @(negedge clk);
    a_mem_req_ready = 1'b1;
    #1;
    checks++; if (a_req_ready !== 2'b10) begin errors++; $display("FAIL bp_refill_grant: got %b want 10", a_req_ready); end
    @(negedge clk); #1;
    checks++; if (a_mem_req_valid !== 1'b1 || a_mem_req.mem_req_addr !== 32'hB0 || a_mem_req.mem_req_id !== 8'hA2) begin
      errors++; $display("FAIL bp_b2b1: got v=%b addr=%h id=%h want v=1 addr=b0 id=a2", a_mem_req_valid, a_mem_req.mem_req_addr, a_mem_req.mem_req_id); end
    checks++; if (a_req_ready !== 2'b01) begin errors++; $display("FAIL bp_b2b_grant: got %b want 01", a_req_ready); end
    @(negedge clk);
    a_req_valid = 2'b00;
    #1;
    checks++; if (a_mem_req_valid !== 1'b1 || a_mem_req.mem_req_addr !== 32'hA1 || a_mem_req.mem_req_id !== 8'h12) begin
      errors++; $display("FAIL bp_b2b2: got v=%b addr=%h id=%h want v=1 addr=a1 id=12", a_mem_req_valid, a_mem_req.mem_req_addr, a_mem_req.mem_req_id); end
    @(negedge clk); #1;
    checks++; if (a_mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", a_mem_req_valid); end
  endtask

  task automatic test_multibeat();
    a_mem_req_ready = 1'b1;
    a_req[1] = mk_req(32'h300, 8'h05);
    @(negedge clk); a_req_valid = 2'b10;
    @(negedge clk);
    @(negedge clk); a_req_valid = 2'b00; #1;
    checks++; if (a_outstanding[1] !== 3'd2) begin errors++; $display("FAIL mb_pre_count: got %0d want 2", a_outstanding[1]); end
    @(negedge clk);
    a_resp_ready = 2'b11;
    a_mem_resp = mk_resp(8'h85, 64'hD0D0_0000_0000_0001, 1'b0);
    a_mem_resp_valid = 1'b1;
    #1;
    checks++; if (a_resp_valid !== 2'b10) begin errors++; $display("FAIL mb_route1: got %b want 10", a_resp_valid); end
    checks++; if (a_resp[1].mem_resp_r_id !== 8'h05 || a_resp[1].mem_resp_r_data !== 64'hD0D0_0000_0000_0001) begin
      errors++; $display("FAIL mb_beat1: got id=%h data=%h want id=05 data=d0d0000000000001", a_resp[1].mem_resp_r_id, a_resp[1].mem_resp_r_data); end
    checks++; if (a_mem_resp_ready !== 1'b1) begin errors++; $display("FAIL mb_ready1: got %b want 1", a_mem_resp_ready); end
    @(negedge clk);
    a_resp_ready = 2'b01;
    a_mem_resp = mk_resp(8'h85, 64'hD1D1_0000_0000_0002, 1'b1);
    #1;
    checks++; if (a_mem_resp_ready !== 1'b0) begin errors++; $display("FAIL mb_stall: got %b want 0", a_mem_resp_ready); end
    checks++; if (a_outstanding[1] !== 3'd2) begin errors++; $display("FAIL mb_mid_count: got %0d want 2", a_outstanding[1]); end
    @(negedge clk);
    a_resp_ready = 2'b11;
    #1;
    checks++; if (a_resp_valid !== 2'b10 || a_resp[1].mem_resp_r_data !== 64'hD1D1_0000_0000_0002 || a_mem_resp_ready !== 1'b1) begin
      errors++; $display("FAIL mb_beat2: got v=%b data=%h rdy=%b want v=10 data=d1d1000000000002 rdy=1", a_resp_valid, a_resp[1].mem_resp_r_data, a_mem_resp_ready); end
    checks++; if (a_outstanding[1] !== 3'd2) begin errors++; $display("FAIL mb_stall_count: got %0d want 2", a_outstanding[1]); end
    @(negedge clk);
    a_mem_resp_valid = 1'b0;
    #1;
    checks++; if (a_outstanding[1] !== 3'd1) begin errors++; $display("FAIL mb_post_count: got %0d want 1", a_outstanding[1]); end
  endtask

  task automatic test_same_cycle();
    a_mem_req_ready = 1'b1;
    a_resp_ready = 2'b11;
    a_req[0] = mk_req(32'h400, 8'h01);
    @(negedge clk); a_req_valid = 2'b01;
    @(negedge clk); a_req_valid = 2'b00; #1;
    checks++; if (a_outstanding[0] !== 3'd1) begin errors++; $display("FAIL sc_pre_count: got %0d want 1", a_outstanding[0]); end
    @(negedge clk);
    a_req_valid = 2'b01;
    a_mem_resp = mk_resp(8'h00, 64'h44, 1'b1);
    a_mem_resp_valid = 1'b1;
    #1;
    checks++; if (a_req_ready !== 2'b01 || a_mem_resp_ready !== 1'b1) begin
      errors++; $display("FAIL sc_both_fire: got rdy=%b resp_rdy=%b want 01/1", a_req_ready, a_mem_resp_ready); end
    @(negedge clk);
    a_req_valid = 2'b00;
    a_mem_resp_valid = 1'b0;
    #1;
    checks++; if (a_outstanding[0] !== 3'd1) begin errors++; $display("FAIL sc_count: got %0d want 1", a_outstanding[0]); end
    checks++; if (a_tid_err !== 1'b0) begin errors++; $display("FAIL sc_no_err: got %b want 0", a_tid_err); end
  endtask

  task automatic test_tid_errors();
    @(negedge clk);
    a_mem_resp = mk_resp(8'h80, 64'h55, 1'b1);
    a_mem_resp_valid = 1'b1;
    #1;
    checks++; if (a_resp_valid !== 2'b10 || a_mem_resp_ready !== 1'b1) begin
      errors++; $display("FAIL spur_route: got v=%b rdy=%b want 10/1", a_resp_valid, a_mem_resp_ready); end
    @(negedge clk);
    a_mem_resp_valid = 1'b0;
    #1;
    checks++; if (a_tid_err !== 1'b1) begin errors++; $display("FAIL spur_err: got %b want 1", a_tid_err); end
    checks++; if (a_outstanding[1] !== 3'd0 || a_outstanding[0] !== 3'd1) begin errors++; $display("FAIL spur_count: got %0d/%0d want 1/0", a_outstanding[0], a_outstanding[1]); end
    @(negedge clk); #1;
    checks++; if (a_tid_err !== 1'b0) begin errors++; $display("FAIL spur_err_clear: got %b want 0", a_tid_err); end
    @(negedge clk);
    a_req[0] = mk_req(32'h500, 8'h8A);
    a_req_valid = 2'b01;
    #1;
    checks++; if (a_req_ready !== 2'b01) begin errors++; $display("FAIL badtid_grant: got %b want 01", a_req_ready); end
    @(negedge clk);
    a_req_valid = 2'b00;
    #1;
    checks++; if (a_mem_req_valid !== 1'b1 || a_mem_req.mem_req_id !== 8'h0A || a_mem_req.mem_req_addr !== 32'h500) begin
      errors++; $display("FAIL badtid_fwd: got v=%b id=%h addr=%h want 1/0a/500", a_mem_req_valid, a_mem_req.mem_req_id, a_mem_req.mem_req_addr); end
    checks++; if (a_tid_err !== 1'b1) begin errors++; $display("FAIL badtid_err: got %b want 1", a_tid_err); end
    @(negedge clk); #1;
    checks++; if (a_tid_err !== 1'b0) begin errors++; $display("FAIL badtid_err_clear: got %b want 0", a_tid_err); end
  endtask

  task automatic test_reset_inflight();
    a_mem_req_ready = 1'b1;
    a_req[0] = mk_req(32'h600, 8'h03);
    @(negedge clk); a_req_valid = 2'b01;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    a_req_valid = 2'b00;
    a_mem_req_ready = 1'b0;
    #1;
    checks++; if (a_mem_req_valid !== 1'b1 || a_outstanding[0] !== 3'd3) begin
      errors++; $display("FAIL ri_setup: got v=%b cnt=%0d want 1/3", a_mem_req_valid, a_outstanding[0]); end
    @(negedge clk);
    rst = 1'b1;
    a_req_valid = 2'b01;
    #1;
    checks++; if (a_req_ready !== 2'b00) begin errors++; $display("FAIL ri_ready_in_rst: got %b want 00", a_req_ready); end
    @(negedge clk); #1;
    checks++; if (a_mem_req_valid !== 1'b0) begin errors++; $display("FAIL ri_valid: got %b want 0", a_mem_req_valid); end
    checks++; if (a_outstanding !== '0) begin errors++; $display("FAIL ri_counts: got %h want 0", a_outstanding); end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_nreq3();
    @(negedge clk);
    b_resp_ready = 3'b000;
    b_mem_resp = mk_resp(8'hC0, 64'h77, 1'b1);
    b_mem_resp_valid = 1'b1;
    #1;
    checks++; if (b_mem_resp_ready !== 1'b1) begin errors++; $display("FAIL n3_drop_ready: got %b want 1", b_mem_resp_ready); end
    checks++; if (b_resp_valid !== 3'b000) begin errors++; $display("FAIL n3_drop_valid: got %b want 000", b_resp_valid); end
    @(negedge clk);
    b_mem_resp_valid = 1'b0;
    #1;
    checks++; if (b_tid_err !== 1'b1) begin errors++; $display("FAIL n3_drop_err: got %b want 1", b_tid_err); end
    checks++; if (b_outstanding !== '0) begin errors++; $display("FAIL n3_drop_counts: got %h want 0", b_outstanding); end
    @(negedge clk); #1;
    checks++; if (b_tid_err !== 1'b0) begin errors++; $display("FAIL n3_err_once: got %b want 0", b_tid_err); end
    b_mem_req_ready = 1'b1;
    b_req[2] = mk_req(32'h700, 8'h05);
    b_req_valid = 3'b100;
    #1;
    checks++; if (b_req_ready !== 3'b100) begin errors++; $display("FAIL n3_grant: got %b want 100", b_req_ready); end
    @(negedge clk);
    b_req_valid = 3'b000;
    #1;
    checks++; if (b_mem_req.mem_req_id !== 8'h85 || b_outstanding[2] !== 3'd1) begin
      errors++; $display("FAIL n3_remap: got id=%h cnt=%0d want 85/1", b_mem_req.mem_req_id, b_outstanding[2]); end
    b_resp_ready = 3'b100;
    b_mem_resp = mk_resp(8'h85, 64'h88, 1'b0);
    b_mem_resp_valid = 1'b1;
    #1;
    checks++; if (b_resp_valid !== 3'b100 || b_resp[2].mem_resp_r_id !== 8'h05 || b_mem_resp_ready !== 1'b1) begin
      errors++; $display("FAIL n3_route: got v=%b id=%h rdy=%b want 100/05/1", b_resp_valid, b_resp[2].mem_resp_r_id, b_mem_resp_ready); end
    @(negedge clk);
    b_mem_resp_valid = 1'b0;
    #1;
    checks++; if (b_tid_err !== 1'b0 || b_outstanding[2] !== 3'd1) begin
      errors++; $display("FAIL n3_nonlast: got err=%b cnt=%0d want 0/1", b_tid_err, b_outstanding[2]); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    do_reset();
    test_outstanding_limit();
    do_reset();
    test_backpressure();
    do_reset();
    test_multibeat();
    do_reset();
    test_same_cycle();
    test_tid_errors();
    do_reset();
    test_reset_inflight();
    test_nreq3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sargantana_hpdc_mem_arbiter.md
SARGANTANA_HPDC_MEM_ARBITER -- requirements
Module: sargantana_hpdc_mem_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2 (HPDCACHE_NREQUESTERS); number of requester channels, range 1..8.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4; per-channel read-request limit, at least 1.
REQ-003 SHALL have parameter TID_WIDTH, default 8 (HPDCACHE_MEM_TID_WIDTH); SRC_W = max(1, clog2(NREQ)), requester TID field = TID_WIDTH-SRC_W bits.
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 req_valid_i / req_ready_o  in/out  NREQ  per-channel request handshake.
REQ-007 req_i  in  NREQ x hpdcache_mem_req_t  per-channel read request.
REQ-008 mem_req_valid_o / mem_req_ready_i  out/in  1  downstream request handshake.
REQ-009 mem_req_o  out  hpdcache_mem_req_t  merged request, TID remapped.
REQ-010 mem_resp_valid_i / mem_resp_ready_o  in/out  1  downstream response handshake.
REQ-011 mem_resp_i  in  hpdcache_mem_resp_r_t  response beat.
REQ-012 resp_valid_o / resp_ready_i  out/in  NREQ  per-channel response handshake.
REQ-013 resp_o  out  NREQ x hpdcache_mem_resp_r_t  routed response, original TID restored.
REQ-014 outstanding_o  out  NREQ x clog2(MAX_OUTSTANDING+1)  per-channel in-flight count.
REQ-015 tid_err_o  out  1  one-cycle pulse on illegal TID (request or response).

Function
REQ-016 Channel i eligible iff req_valid_i[i], outstanding[i] < MAX_OUTSTANDING, output register free or draining this cycle.
REQ-017 Round-robin among eligible channels; priority pointer moves to winner+1 (mod NREQ) on each grant; pointer 0 after reset.
REQ-018 req_ready_o[i] high only for the granted channel; at most one req_ready_o bit high per cycle.
REQ-019 Accepted request stored in a one-entry output register; mem_req_valid_o asserts the next cycle (latency 1).
REQ-020 mem_req_o and mem_req_valid_o held stable until mem_req_ready_i; accept-and-refill in the same cycle permitted (full throughput).
REQ-021 Downstream TID = {source index (SRC_W), requester TID low bits}; all other request fields pass unchanged.
REQ-022 Request whose upper SRC_W TID bits are non-zero: still forwarded (bits overwritten), tid_err_o pulsed.
REQ-023 outstanding[i] increments on request acceptance at the arbiter; decrements on acceptance of a response beat with mem_resp_r_last set; both in one cycle -> unchanged.
REQ-024 Response routed combinationally: resp_valid_o[src] = mem_resp_valid_i, mem_resp_ready_o = resp_ready_i[src]; upper TID bits zeroed in resp_o.
REQ-025 Response with src >= NREQ: mem_resp_ready_o high (beat dropped), no resp_valid_o, tid_err_o pulsed, no counter change.
REQ-026 Decrement at outstanding = 0 (spurious last beat): counter saturates at 0, tid_err_o pulsed.
REQ-027 Multi-beat responses stay ordered per channel; no buffering on the response path.

Reset
REQ-028 With rst_i high at a clock edge: output register empty, mem_req_valid_o=0, all counters 0, pointer 0, tid_err_o=0. Any in-flight request is discarded.
REQ-029 During reset, req_ready_o=0 and mem_resp_ready_o=0.

Structure
REQ-030 SRC_W helper, counter type and the remapped-TID layout SHALL be in sargantana_hpdc_pkg next to the existing mem types.
REQ-031 Round-robin selection SHALL be a sub-module sargantana_rr_arbiter (NREQ req, one-hot grant, pointer update on enable).

Verification
REQ-032 Both channels valid for 4 cycles, ready=1: grants ch0,ch1,ch0,ch1; downstream TIDs 0x0A -> 0x0A, 0x0A -> 0x8A.
REQ-033 Ch0 issues 4 requests, no responses: 5th request stalled (req_ready_o[0]=0, outstanding_o[0]=4); ch1 still served.
REQ-034 mem_req_ready_i low 3 cycles: mem_req_o stable and no new grant; after release, back-to-back transfers at 1/cycle.
REQ-035 2-beat response TID 0x85 (last on beat 2): routed to ch1 with TID 0x05; outstanding_o[1] falls by 1 only after beat 2.
REQ-036 Request acceptance and last-beat response on ch0 in the same cycle: outstanding_o[0] unchanged.
REQ-037 rst_i asserted with a request pending and count 3: next cycle mem_req_valid_o=0, all counts 0. NREQ=3, response TID 0xC0: dropped, tid_err_o pulses once.
